md_sequencer: RTL

//  Multi-cycle multiply/divide controller for the EX stage. Accepts MDFunc/MDSign ops from ID_EX,

---
 rtl/md_sequencer_pkg.sv | 27 ++
 rtl/md_sequencer_if.sv | 23 ++
 rtl/md_sequencer_div_core.sv | 94 +++++++++
 rtl/md_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared types for the EX-stage multiply/divide sequencer.
// Function codes follow EX_CTRL.MDFunc; encodings 5..7 decode as no operation.
package md_sequencer_pkg;

    typedef enum logic [2:0] {
        MD_NONE = 3'b000,
        MD_MULT = 3'b001,
        MD_DIV  = 3'b010,
        MD_MTHI = 3'b011,
        MD_MTLO = 3'b100
    } md_func_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE,
        MD_ST_MUL,
        MD_ST_DIV,
        MD_ST_DFIX
    } md_state_e;

    localparam int unsigned DIV_ITERS = 32;

    function automatic logic md_func_valid(input logic [2:0] func);
        return (func == MD_MULT) || (func == MD_DIV) ||
               (func == MD_MTHI) || (func == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage request/response bundle between ID_EX control and the sequencer.
interface md_sequencer_if;
    logic [2:0]  md_func;
    logic        md_sign;
    logic        md_hi_rd;
    logic        md_lo_rd;
    logic        ex_flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] md_out;
    logic        md_busy;
    logic        md_stall;

    modport master (
        output md_func, md_sign, md_hi_rd, md_lo_rd, ex_flush, op_a, op_b,
        input  md_out, md_busy, md_stall
    );

    modport slave (
        input  md_func, md_sign, md_hi_rd, md_lo_rd, ex_flush, op_a, op_b,
        output md_out, md_busy, md_stall
    );
endinterface

// File: rtl/md_sequencer_div_core.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle after start,
// with sign fix-up and divide-by-zero results presented combinationally.
module md_div_core
    import md_sequencer_pkg::*;
#(
    parameter int unsigned ITERS = DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        done
);

    logic        run;
    logic        done_q;
    logic [5:0]  iter;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] div_q;
    logic [31:0] a_raw;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic        qbit;

    assign a_neg = sign & a[31];
    assign b_neg = sign & b[31];
    assign a_abs = a_neg ? (32'd0 - a) : a;
    assign b_abs = b_neg ? (32'd0 - b) : b;

    always_comb begin
        shifted  = {rem_q, quot_q[31]};
        diff     = shifted - {1'b0, div_q};
        rem_next = shifted[31:0];
        qbit     = 1'b0;
        if (!diff[32]) begin
            rem_next = diff[31:0];
            qbit     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            done_q   <= 1'b0;
            iter     <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            run      <= 1'b1;
            done_q   <= 1'b0;
            iter     <= '0;
            rem_q    <= '0;
            quot_q   <= a_abs;
            div_q    <= b_abs;
            a_raw    <= a;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
        end else if (run) begin
            rem_q  <= rem_next;
            quot_q <= {quot_q[30:0], qbit};
            iter   <= iter + 6'd1;
            if (iter == 6'(ITERS - 1)) begin
                run    <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // Divide-by-zero bypasses the sign rules so HI keeps the raw dividend.
    assign quot = div_zero ? '1    : (neg_q ? (32'd0 - quot_q) : quot_q);
    assign rem  = div_zero ? a_raw : (neg_r ? (32'd0 - rem_q) : rem_q);
    assign done = done_q;

endmodule

// File: rtl/md_sequencer.sv
// EX-stage multiply/divide controller: owns HI/LO, sequences MULT/DIV and
// stalls the pipeline while the EX instruction needs HI/LO before they settle.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_ITERS  = md_sequencer_pkg::DIV_ITERS
) (
    input  logic           clk,
    input  logic           rst_n,
    md_sequencer_if.slave  md
);

    md_state_e   state;
    logic [5:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;

    logic        accept;
    logic        div_start;
    logic        uses;
    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] product;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        div_done;

    assign accept    = (state == MD_ST_IDLE) & ~md.ex_flush & md_func_valid(md.md_func);
    assign div_start = accept & (md.md_func == MD_DIV);
    assign uses      = (md.md_func != '0) | md.md_hi_rd | md.md_lo_rd;

    // Extending to 64 bits first makes one multiplier serve signed and unsigned.
    assign mul_ext_a = mul_sign ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
    assign mul_ext_b = mul_sign ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
    assign product   = mul_ext_a * mul_ext_b;

    md_div_core #(
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .a     (md.op_a),
        .b     (md.op_b),
        .sign  (md.md_sign),
        .quot  (div_quot),
        .rem   (div_rem),
        .done  (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MD_ST_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_sign <= 1'b0;
        end else begin
            case (state)
                MD_ST_IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        case (md.md_func)
                            MD_MULT: begin
                                mul_a    <= md.op_a;
                                mul_b    <= md.op_b;
                                mul_sign <= md.md_sign;
                                state    <= MD_ST_MUL;
                                busy     <= 1'b1;
                            end
                            MD_DIV: begin
                                state <= MD_ST_DIV;
                                busy  <= 1'b1;
                            end
                            MD_MTHI: hi <= md.op_a;
                            MD_MTLO: lo <= md.op_a;
                            default: ;
                        endcase
                    end
                end
                MD_ST_MUL: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(MUL_CYCLES - 1)) begin
                        hi    <= product[63:32];
                        lo    <= product[31:0];
                        state <= MD_ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                MD_ST_DIV: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(DIV_ITERS - 1)) begin
                        state <= MD_ST_DFIX;
                    end
                end
                MD_ST_DFIX: begin
                    cnt <= cnt + 6'd1;
                    if (div_done) begin
                        hi    <= div_rem;
                        lo    <= div_quot;
                        state <= MD_ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= MD_ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign md.md_out   = md.md_hi_rd ? hi : lo;
    assign md.md_busy  = busy;
    assign md.md_stall = busy & uses & ~md.ex_flush;

endmodule
